ahb_slave_if: RTL

AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

---
 rtl/ahb_slave_if_pkg.sv | 25 ++
 rtl/ahb_slave_if_if.sv | 38 +++
 rtl/ahb_addr_decode.sv | 28 ++
 rtl/ahb_slave_if.sv | 103 ++++++++++
 4 files changed

// File: rtl/ahb_slave_if_pkg.sv
// Shared encodings and defaults for the AHB slave interface of the AHB-to-APB bridge.
package ahb_slave_if_pkg;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HrespOkay  = 2'b00,
        HrespError = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        StOkay,
        StErr1,
        StErr2
    } resp_state_e;

    localparam logic [31:0] DefaultBaseAddr = 32'h8000_0000;
    localparam logic [31:0] DefaultSlvSpan  = 32'h0400_0000;

endpackage

// File: rtl/ahb_slave_if_if.sv
// AHB-side bus bundle between the master/bridge FSM and ahb_slave_if.
interface ahb_slave_if_if #(
    parameter int unsigned NUM_SLV = 3
) ();

    logic [1:0]         htrans;
    logic               hwrite;
    logic               hready_in;
    logic [31:0]        haddr;
    logic [31:0]        hwdata;
    logic [31:0]        prdata;
    logic               fsm_ready;

    logic               valid;
    logic [31:0]        haddr1;
    logic [31:0]        haddr2;
    logic [31:0]        hwdata1;
    logic [31:0]        hwdata2;
    logic               hwrite_reg;
    logic               hwrite_reg1;
    logic [NUM_SLV-1:0] tempselx;
    logic [31:0]        hrdata;
    logic [1:0]         hresp;
    logic               hready_out;

    modport slave (
        input  htrans, hwrite, hready_in, haddr, hwdata, prdata, fsm_ready,
        output valid, haddr1, haddr2, hwdata1, hwdata2, hwrite_reg, hwrite_reg1,
               tempselx, hrdata, hresp, hready_out
    );

    modport master (
        output htrans, hwrite, hready_in, haddr, hwdata, prdata, fsm_ready,
        input  valid, haddr1, haddr2, hwdata1, hwdata2, hwrite_reg, hwrite_reg1,
               tempselx, hrdata, hresp, hready_out
    );

endinterface

// File: rtl/ahb_addr_decode.sv
// Combinational APB window check and one-hot slave select.
module ahb_addr_decode
    import ahb_slave_if_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
    parameter logic [31:0] SLV_SPAN  = DefaultSlvSpan,
    parameter int unsigned NUM_SLV   = 3
) (
    input  logic [31:0]        haddr,
    output logic               in_window,
    output logic [NUM_SLV-1:0] tempselx
);

    logic [31:0] offset;
    logic [31:0] index;

    always_comb begin
        offset    = haddr - BASE_ADDR;
        index     = offset / SLV_SPAN;
        // The lower-bound check guards against the subtraction wrapping below the base.
        in_window = (haddr >= BASE_ADDR) && (index < NUM_SLV);
        tempselx  = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            tempselx[i] = in_window && (index == i);
        end
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB slave front end: address/data pipeline, window decode and optional ERROR response.
// Optional feature: define AHB_SLV_ERR_RESP_EN for the two-cycle ERROR response and err_cnt.
module ahb_slave_if
    import ahb_slave_if_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
    parameter logic [31:0] SLV_SPAN  = DefaultSlvSpan,
    parameter int unsigned NUM_SLV   = 3
) (
    input  logic          hclk,
    input  logic          hresetn,
    ahb_slave_if_if.slave bus
);

    logic in_window;
    logic active_trans;

    ahb_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .SLV_SPAN  (SLV_SPAN),
        .NUM_SLV   (NUM_SLV)
    ) u_decode (
        .haddr     (bus.haddr),
        .in_window (in_window),
        .tempselx  (bus.tempselx)
    );

    assign active_trans = (bus.htrans == HtransNonseq) || (bus.htrans == HtransSeq);
    assign bus.valid    = bus.hready_in && active_trans && in_window;
    assign bus.hrdata   = bus.prdata;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            bus.haddr1      <= '0;
            bus.haddr2      <= '0;
            bus.hwdata1     <= '0;
            bus.hwdata2     <= '0;
            bus.hwrite_reg  <= 1'b0;
            bus.hwrite_reg1 <= 1'b0;
        end else if (bus.hready_in) begin
            bus.haddr1      <= bus.haddr;
            bus.haddr2      <= bus.haddr1;
            bus.hwdata1     <= bus.hwdata;
            bus.hwdata2     <= bus.hwdata1;
            bus.hwrite_reg  <= bus.hwrite;
            bus.hwrite_reg1 <= bus.hwrite_reg;
        end
    end

`ifdef AHB_SLV_ERR_RESP_EN
    resp_state_e state_q, state_d;
    logic [7:0]  err_cnt;
    logic        err_start;
    hresp_e      hresp;
    logic        hready_out;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= StOkay;
            err_cnt <= 8'd0;
        end else begin
            state_q <= state_d;
            if (err_start && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Only the OKAY state looks at the bus; an error response runs to completion.
    always_comb begin
        state_d    = state_q;
        err_start  = 1'b0;
        hresp      = HrespOkay;
        hready_out = bus.fsm_ready;
        unique case (state_q)
            StOkay: begin
                if (bus.hready_in && active_trans && !in_window) begin
                    err_start = 1'b1;
                    state_d   = StErr1;
                end
            end
            StErr1: begin
                hresp      = HrespError;
                hready_out = 1'b0;
                state_d    = StErr2;
            end
            StErr2: begin
                hresp      = HrespError;
                hready_out = 1'b1;
                state_d    = StOkay;
            end
            default: state_d = StOkay;
        endcase
    end

    assign bus.hresp      = hresp;
    assign bus.hready_out = hready_out;
`else
    assign bus.hresp      = HrespOkay;
    assign bus.hready_out = bus.fsm_ready;
`endif

endmodule
